// File: rtl/cmp_mon_pkg.sv
// Shared types for the comparator debounce monitor: FSM states, sample classes
// and the flag-to-class decode.
package cmp_mon_pkg;

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        ARMING    = 2'd1,
        ALARM     = 2'd2,
        RELEASING = 2'd3
    } mon_state_t;

    typedef enum logic [1:0] {
        S_HI  = 2'd0,
        S_LO  = 2'd1,
        S_BAD = 2'd2
    } sample_t;

    // Only a one-hot flag triple is a legal comparator result.
    function automatic sample_t classify(input logic gt, input logic lt, input logic eq);
        sample_t cls;
        case ({gt, lt, eq})
            3'b100:         cls = S_HI;
            3'b010, 3'b001: cls = S_LO;
            default:        cls = S_BAD;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment in the
// same cycle yields 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != MAX_VAL)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/cmp_debounce_monitor.sv
// Debounces comparator GT/LT/EQ flags with symmetric N-sample hysteresis and
// reports a registered alarm level, edge pulses, an event count and a sticky error.
module cmp_debounce_monitor
    import cmp_mon_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             gt_i,
    input  logic             lt_i,
    input  logic             eq_i,
    input  logic             clr_i,
    output logic             alarm_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] event_cnt_o,
    output logic             err_o
);

    localparam int RW = $clog2(N + 1);
    // run holds the number of agreeing samples already seen, so the Nth one
    // arrives while run equals N-1.
    localparam logic [RW-1:0] RUN_LAST = RW'(N - 1);
    localparam logic [RW-1:0] RUN_ONE  = RW'(1);

    mon_state_t    state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic          alarm_q, alarm_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          err_q, err_d;
    sample_t       cls;

    assign cls = classify(gt_i, lt_i, eq_i);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        err_d   = err_q;

        if (clr_i) begin
            err_d = 1'b0;
        end

        if (valid_i) begin
            if (cls == S_BAD) begin
                err_d = 1'b1;
            end else begin
                case (state_q)
                    CLEAR: begin
                        if (cls == S_HI) begin
                            if (N == 1) begin
                                state_d = ALARM;
                                rise_d  = 1'b1;
                            end else begin
                                state_d = ARMING;
                                run_d   = RUN_ONE;
                            end
                        end
                    end
                    ARMING: begin
                        if (cls == S_HI) begin
                            if (run_q == RUN_LAST) begin
                                state_d = ALARM;
                                run_d   = '0;
                                rise_d  = 1'b1;
                            end else begin
                                run_d = run_q + RUN_ONE;
                            end
                        end else begin
                            state_d = CLEAR;
                            run_d   = '0;
                        end
                    end
                    ALARM: begin
                        if (cls == S_LO) begin
                            if (N == 1) begin
                                state_d = CLEAR;
                                fall_d  = 1'b1;
                            end else begin
                                state_d = RELEASING;
                                run_d   = RUN_ONE;
                            end
                        end
                    end
                    RELEASING: begin
                        if (cls == S_LO) begin
                            if (run_q == RUN_LAST) begin
                                state_d = CLEAR;
                                run_d   = '0;
                                fall_d  = 1'b1;
                            end else begin
                                run_d = run_q + RUN_ONE;
                            end
                        end else begin
                            state_d = ALARM;
                            run_d   = '0;
                        end
                    end
                    default: begin
                        state_d = CLEAR;
                        run_d   = '0;
                    end
                endcase
            end
        end

        alarm_d = (state_d == ALARM) || (state_d == RELEASING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            run_q   <= '0;
            alarm_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            alarm_q <= alarm_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            err_q   <= err_d;
        end
    end

    // Counting on rise_d keeps event_cnt_o in step with the rise_o pulse.
    sat_counter #(
        .W(CNT_W)
    ) u_event_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clr_i),
        .inc(rise_d),
        .q  (event_cnt_o)
    );

    assign alarm_o = alarm_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_cmp_debounce_monitor.sv
// Directed plus randomized bench for cmp_debounce_monitor (N=3, CNT_W=4) against
// a streak-counting reference model.
module tb_cmp_debounce_monitor;

    localparam int N     = 3;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_i = 1'b0;
    logic             gt_i = 1'b0;
    logic             lt_i = 1'b0;
    logic             eq_i = 1'b0;
    logic             clr_i = 1'b0;
    logic             alarm_o;
    logic             rise_o;
    logic             fall_o;
    logic [CNT_W-1:0] event_cnt_o;
    logic             err_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: debounced level plus count of consecutive samples
    // disagreeing with it; N in a row flips the level.
    bit m_alarm;
    int m_streak;
    bit m_rise;
    bit m_fall;
    bit m_err;
    int m_cnt;

    cmp_debounce_monitor #(
        .N    (N),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .gt_i       (gt_i),
        .lt_i       (lt_i),
        .eq_i       (eq_i),
        .clr_i      (clr_i),
        .alarm_o    (alarm_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .event_cnt_o(event_cnt_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_alarm  = 1'b0;
        m_streak = 0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_err    = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic model_step(input bit v, input bit g, input bit l, input bit e, input bit c);
        bit is_hi;
        bit is_lo;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (c) begin
            m_cnt = 0;
            m_err = 1'b0;
        end
        if (v) begin
            is_hi = ({g, l, e} == 3'b100);
            is_lo = ({g, l, e} == 3'b010) || ({g, l, e} == 3'b001);
            if (!is_hi && !is_lo) begin
                m_err = 1'b1;
            end else if (is_hi != m_alarm) begin
                m_streak++;
                if (m_streak == N) begin
                    m_streak = 0;
                    m_alarm  = is_hi;
                    if (is_hi) begin
                        m_rise = 1'b1;
                        if (m_cnt < CMAX) m_cnt++;
                    end else begin
                        m_fall = 1'b1;
                    end
                end
            end else begin
                m_streak = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".alarm"}, 32'(alarm_o), 32'(m_alarm));
        chk({tag, ".rise"}, 32'(rise_o), 32'(m_rise));
        chk({tag, ".fall"}, 32'(fall_o), 32'(m_fall));
        chk({tag, ".cnt"}, 32'(event_cnt_o), 32'(m_cnt));
        chk({tag, ".err"}, 32'(err_o), 32'(m_err));
    endtask

    task automatic step(input string tag, input bit v, input bit g, input bit l, input bit e,
                        input bit c);
        @(negedge clk);
        valid_i = v;
        gt_i    = g;
        lt_i    = l;
        eq_i    = e;
        clr_i   = c;
        @(posedge clk);
        model_step(v, g, l, e, c);
        #1;
        check_all(tag);
    endtask

    task automatic hi(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lo(input string tag, input int n);
        bit pick;
        for (int i = 0; i < n; i++) begin
            pick = 1'($urandom_range(0, 1));
            step(tag, 1'b1, 1'b0, pick, ~pick, 1'b0);
        end
    endtask

    // Flags carry junk during gaps; they must be ignored.
    task automatic gap(input string tag, input int n);
        logic [2:0] junk;
        for (int i = 0; i < n; i++) begin
            junk = 3'($urandom_range(0, 7));
            step(tag, 1'b0, junk[2], junk[1], junk[0], 1'b0);
        end
    endtask

    task automatic reset_mid(input string tag);
        @(negedge clk);
        valid_i = 1'b0;
        gt_i    = 1'b0;
        lt_i    = 1'b0;
        eq_i    = 1'b0;
        clr_i   = 1'b0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [2:0] bad_pats [5];
        logic [2:0] pat;
        bit         phase;
        int         r;

        bad_pats = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        model_reset();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("reset");

        // Reset aborts a partial run, then a full run raises the alarm.
        hi("arming", 2);
        reset_mid("reset_mid_arming");
        hi("post_reset_rise", 3);
        step("rise_pulse_end", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset while in ALARM drops the level with no fall pulse.
        reset_mid("reset_in_alarm");

        hi("broken_hi", 2);
        lo("broken_lo", 1);
        hi("broken_hi2", 2);
        hi("broken_rise", 1);

        lo("rel_lo", 2);
        hi("rel_hi", 1);
        lo("rel_fall", 3);
        gap("rel_idle", 1);

        hi("gap_hi", 1);
        gap("gap5", 5);
        hi("gap_hi", 1);
        gap("gap1", 1);
        hi("gap_rise", 1);
        lo("gap_release", 3);

        hi("bad_arm", 2);
        step("bad_110", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        hi("bad_rise", 1);
        lo("bad_release", 3);
        step("clr_only", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("bad_set", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step("clr_with_bad", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        for (int k = 0; k < 17; k++) begin
            hi("sat_hi", 3);
            lo("sat_lo", 3);
        end
        hi("clr_rise_arm", 2);
        step("clr_with_rise", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        lo("clr_rise_release", 3);

        phase = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ((k % 8) == 0) phase = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                pat = 3'($urandom_range(0, 7));
                step("rnd_gap", 1'b0, pat[2], pat[1], pat[0], (r < 1));
            end else if (r < 14) begin
                pat = bad_pats[$urandom_range(0, 4)];
                step("rnd_bad", 1'b1, pat[2], pat[1], pat[0], (r < 10));
            end else begin
                if ((int'($urandom_range(0, 99)) < 80) == phase) begin
                    pat = 3'b100;
                end else begin
                    pat = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b001;
                end
                step("rnd_smp", 1'b1, pat[2], pat[1], pat[0], (r > 96));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
